// File: rtl/ahb_line_fill_master_if.sv
// AHB-Lite read-only bus bundle between the line-fill master and memory.
// Ports: haddr/htrans/hburst/hsize/hwrite from master; hready/hresp/hrdata from slave.
interface ahb_line_fill_master_if #(
    parameter int ADDR_BITS = 32
);
    logic [ADDR_BITS-1:0] haddr;
    logic [1:0]           htrans;
    logic [2:0]           hburst;
    logic [2:0]           hsize;
    logic                 hwrite;
    logic                 hready;
    logic                 hresp;
    logic [31:0]          hrdata;

    modport master (
        output haddr, htrans, hburst, hsize, hwrite,
        input  hready, hresp, hrdata
    );

    modport slave (
        input  haddr, htrans, hburst, hsize, hwrite,
        output hready, hresp, hrdata
    );
endinterface

// File: rtl/ahb_line_fill_master.sv
// I-cache line-fill master: one critical-word-first WRAP4 read per request.
// Ports: hclk/hrst; fill_req/fill_addr in; fill_busy/done/err/line out; bus = AHB master.
module ahb_line_fill_master #(
    parameter int LINE_BITS = 128,
    parameter int ADDR_BITS = 32
) (
    input  logic                   hclk,
    input  logic                   hrst,
    input  logic                   fill_req,
    input  logic [ADDR_BITS-1:0]   fill_addr,
    output logic                   fill_busy,
    output logic                   fill_done,
    output logic                   fill_err,
    output logic [LINE_BITS-1:0]   fill_line,
    ahb_line_fill_master_if.master bus
);
    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;
    localparam logic [2:0] BU_SINGLE = 3'b000;
    localparam logic [2:0] BU_WRAP4  = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_BURST,
        S_DATA_LAST,
        S_ERR2,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_BITS-1:4]   base_q, base_d;
    logic [1:0]             w0_q, w0_d;
    logic [1:0]             acnt_q, acnt_d;
    logic [1:0]             dcnt_q, dcnt_d;
    logic [ADDR_BITS-1:0]   haddr_q, haddr_d;
    logic [1:0]             htrans_q, htrans_d;
    logic [2:0]             hburst_q, hburst_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic [LINE_BITS-1:0]   line_q, line_d;

    // Word index of the next address beat and of the pending data beat;
    // 2-bit sums wrap inside the 16-byte line.
    logic [1:0] aidx_nxt;
    logic [1:0] didx;
    assign aidx_nxt = w0_q + acnt_q + 2'd1;
    assign didx     = w0_q + dcnt_q;

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^fill_addr[1:0];

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        w0_d     = w0_q;
        acnt_d   = acnt_q;
        dcnt_d   = dcnt_q;
        haddr_d  = haddr_q;
        htrans_d = htrans_q;
        hburst_d = hburst_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        line_d   = line_q;
        unique case (state_q)
            S_IDLE: begin
                busy_d   = 1'b0;
                htrans_d = TR_IDLE;
                hburst_d = BU_SINGLE;
                if (fill_req) begin
                    base_d   = fill_addr[ADDR_BITS-1:4];
                    w0_d     = fill_addr[3:2];
                    acnt_d   = 2'd0;
                    dcnt_d   = 2'd0;
                    haddr_d  = {fill_addr[ADDR_BITS-1:4], fill_addr[3:2], 2'b00};
                    htrans_d = TR_NONSEQ;
                    hburst_d = BU_WRAP4;
                    busy_d   = 1'b1;
                    state_d  = S_ADDR;
                end
            end
            S_ADDR: begin
                // No data phase yet, so hresp cannot refer to this burst.
                if (bus.hready) begin
                    acnt_d   = 2'd1;
                    haddr_d  = {base_q, aidx_nxt, 2'b00};
                    htrans_d = TR_SEQ;
                    state_d  = S_BURST;
                end
            end
            S_BURST: begin
                if (bus.hresp) begin
                    htrans_d = TR_IDLE;
                    state_d  = S_ERR2;
                end else if (bus.hready) begin
                    line_d[{didx, 5'd0} +: 32] = bus.hrdata;
                    dcnt_d = dcnt_q + 2'd1;
                    if (acnt_q == 2'd3) begin
                        htrans_d = TR_IDLE;
                        state_d  = S_DATA_LAST;
                    end else begin
                        acnt_d   = acnt_q + 2'd1;
                        haddr_d  = {base_q, aidx_nxt, 2'b00};
                        htrans_d = TR_SEQ;
                    end
                end
            end
            S_DATA_LAST: begin
                if (bus.hresp) begin
                    state_d = S_ERR2;
                end else if (bus.hready) begin
                    line_d[{didx, 5'd0} +: 32] = bus.hrdata;
                    done_d   = 1'b1;
                    hburst_d = BU_SINGLE;
                    state_d  = S_DONE;
                end
            end
            S_ERR2: begin
                // busy stays high through the error pulse cycle
                if (bus.hready) begin
                    err_d    = 1'b1;
                    hburst_d = BU_SINGLE;
                    state_d  = S_IDLE;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            state_q  <= S_IDLE;
            base_q   <= '0;
            w0_q     <= 2'd0;
            acnt_q   <= 2'd0;
            dcnt_q   <= 2'd0;
            haddr_q  <= '0;
            htrans_q <= TR_IDLE;
            hburst_q <= BU_SINGLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            line_q   <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            w0_q     <= w0_d;
            acnt_q   <= acnt_d;
            dcnt_q   <= dcnt_d;
            haddr_q  <= haddr_d;
            htrans_q <= htrans_d;
            hburst_q <= hburst_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            line_q   <= line_d;
        end
    end

    assign bus.haddr  = haddr_q;
    assign bus.htrans = htrans_q;
    assign bus.hburst = hburst_q;
    assign bus.hsize  = 3'b010;
    assign bus.hwrite = 1'b0;

    assign fill_busy = busy_q;
    assign fill_done = done_q;
    assign fill_err  = err_q;
    assign fill_line = line_q;
endmodule
